// File: rtl/ula_seq.sv
// ula_seq: handshaked nRisc ULA with registered single-cycle ops
// and a shift-add multiplier.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Carry,
  output logic             Ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int W2  = 2 * WIDTH;

  localparam logic [3:0] OP_SLT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_ADD = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mult_q, mult_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   incr;
  logic [SHW-1:0]   shamt;

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == HOLD) & out_ready);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  assign sum   = {1'b0, A} + {1'b0, B};
  assign diff  = {1'b0, A} - {1'b0, B};
  assign incr  = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = B[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ALUctl)
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_AND: alu_res = A & B;
      OP_MOV: alu_res = B;
      OP_OR:  alu_res = A | B;
      OP_INC: begin
        alu_res   = incr[WIDTH-1:0];
        alu_carry = incr[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      OP_XOR: alu_res = A ^ B;
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SHL: alu_res = A << shamt;
      OP_SHR: alu_res = A >> shamt;
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
      end
      MUL: begin
        if (cnt_q == '0) begin
          res_d   = acc_q[WIDTH-1:0];
          zero_d  = (acc_q[WIDTH-1:0] == '0);
          ovf_d   = |acc_q[W2-1:WIDTH];
          carry_d = 1'b0;
          state_d = HOLD;
        end else begin
          if (mult_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mult_d  = mult_q >> 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a new accept overrides the idle/release transition above
    if (accept) begin
      if (ALUctl == OP_MUL) begin
        mcand_d = {{WIDTH{1'b0}}, A};
        mult_d  = B;
        acc_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = MUL;
      end else begin
        res_d   = alu_res;
        zero_d  = (alu_res == '0);
        carry_d = alu_carry;
        ovf_d   = 1'b0;
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALUOut = res_q;
  assign Zero   = zero_q;
  assign Carry  = carry_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed WIDTH=8 checks plus random
// scoreboard sweeps at WIDTH=2 and WIDTH=16.
module tb_ula_seq;

  logic clk;
  logic rst_n;
  logic rst_sw_n;
  int   nchk;
  int   nerr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_sw_n = 1'b0;
    #23 rst_sw_n = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // returns {ovf, carry, zero, result}
  function automatic logic [34:0] model(
      input int w, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, r, t, a64, b64;
    logic c, v;
    int sh;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    m   = (64'd1 << w) - 64'd1;
    r   = '0;
    t   = '0;
    c   = 1'b0;
    v   = 1'b0;
    sh  = int'(b[4:0]) & (w - 1);
    case (op)
      4'd0: r = {63'd0, (a64 < b64)};
      4'd1: r = a64 & b64;
      4'd2: r = b64;
      4'd3: r = a64 | b64;
      4'd4: begin
        t = a64 + 64'd1;
        r = t & m;
        c = t[w];
      end
      4'd5: begin
        t = a64 - b64;
        r = t & m;
        c = (a64 < b64);
      end
      4'd6: r = a64 ^ b64;
      4'd7: begin
        t = a64 + b64;
        r = t & m;
        c = t[w];
      end
      4'd8: begin
        t = a64 * b64;
        r = t & m;
        v = ((t >> w) != 64'd0);
      end
      4'd9:  r = (a64 << sh) & m;
      4'd10: r = a64 >> sh;
      default: r = '0;
    endcase
    return {v, c, (r == 64'd0), r[31:0]};
  endfunction

  logic       iv, ir, ov, ordy;
  logic [3:0] ctl;
  logic [7:0] a, b, res;
  logic       zf, cf, vf;
  logic [34:0] q[$];

  ula_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .ALUctl(ctl), .A(a), .B(b),
    .out_valid(ov), .out_ready(ordy),
    .ALUOut(res), .Zero(zf),
    .Carry(cf), .Ovf(vf)
  );

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (ov && ordy) begin
        if (q.size() == 0)
          chk("sb8_dup", 64'd1, 64'd0);
        else
          chk("sb8", 64'({vf, cf, zf, 24'd0, res}),
              64'(q.pop_front()));
      end
      if (iv && ir)
        q.push_back(model(8, ctl, {24'd0, a},
                          {24'd0, b}));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : sw
      localparam int W = (gi == 0) ? 2 : 16;
      logic         siv, sir, sov, sor;
      logic [3:0]   sctl;
      logic [W-1:0] sa, sb, sres;
      logic         szf, scf, svf;
      logic [34:0]  sq[$];
      int           nacc;
      logic         done;

      ula_seq #(.WIDTH(W)) u (
        .clk(clk), .rst_n(rst_sw_n),
        .in_valid(siv), .in_ready(sir),
        .ALUctl(sctl), .A(sa), .B(sb),
        .out_valid(sov), .out_ready(sor),
        .ALUOut(sres), .Zero(szf),
        .Carry(scf), .Ovf(svf)
      );

      always @(negedge clk) begin
        if (rst_sw_n) begin
          if (sov && sor) begin
            if (sq.size() == 0)
              chk($sformatf("sw%0d_dup", W),
                  64'd1, 64'd0);
            else
              chk($sformatf("sw%0d", W),
                  64'({svf, scf, szf, 32'(sres)}),
                  64'(sq.pop_front()));
          end
          if (siv && sir) begin
            sq.push_back(model(W, sctl, 32'(sa),
                               32'(sb)));
            nacc++;
          end
        end
      end

      initial begin
        done = 1'b0;
        nacc = 0;
        siv  = 1'b0;
        sor  = 1'b0;
        sctl = '0;
        sa   = '0;
        sb   = '0;
        repeat (5) @(posedge clk);
        for (int c = 0; c < 40000 &&
             !(nacc >= 1000 && sq.size() == 0
               && !sov); c++) begin
          @(posedge clk);
          #1;
          siv  = (nacc < 1000) &&
                 ($urandom_range(0, 3) != 0);
          sctl = 4'($urandom_range(0, 15));
          sa   = W'($urandom);
          sb   = W'($urandom);
          sor  = (nacc >= 1000) ||
                 ($urandom_range(0, 3) != 0);
        end
        chk($sformatf("sw%0d_ntx", W),
            64'(nacc), 64'd1000);
        chk($sformatf("sw%0d_lost", W),
            64'(sq.size()), 64'd0);
        done = 1'b1;
      end
    end
  endgenerate

  task automatic drive(input logic [3:0] op,
                       input logic [7:0] xa,
                       input logic [7:0] xb);
    int n;
    ctl = op;
    a   = xa;
    b   = xb;
    iv  = 1'b1;
    n   = 0;
    @(negedge clk);
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir) chk("accept_to", 64'd0, 64'd1);
    @(posedge clk);
    #1 iv = 1'b0;
  endtask

  task automatic single(input logic [3:0] op,
                        input logic [7:0] xa,
                        input logic [7:0] xb,
                        input logic [7:0] er,
                        input logic ez,
                        input logic ec);
    drive(op, xa, xb);
    @(negedge clk);
    chk($sformatf("op%0d_valid", op), 64'(ov), 64'd1);
    chk($sformatf("op%0d_res", op), 64'(res), 64'(er));
    chk($sformatf("op%0d_zero", op), 64'(zf), 64'(ez));
    chk($sformatf("op%0d_carry", op), 64'(cf), 64'(ec));
    chk($sformatf("op%0d_ovf", op), 64'(vf), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic mul_run(input logic [7:0] xa,
                         input logic [7:0] xb,
                         input logic [7:0] er,
                         input logic ez,
                         input logic ev);
    int  j;
    logic irbad;
    drive(4'd8, xa, xb);
    j     = 0;
    irbad = 1'b0;
    @(negedge clk);
    while (!ov && j < 40) begin
      if (ir) irbad = 1'b1;
      @(negedge clk);
      j++;
    end
    chk("mul_lat", 64'(j), 64'd9);
    chk("mul_inready", 64'(irbad), 64'd0);
    chk("mul_res", 64'(res), 64'(er));
    chk("mul_zero", 64'(zf), 64'(ez));
    chk("mul_ovf", 64'(vf), 64'(ev));
    chk("mul_carry", 64'(cf), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    int   n;
    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b1;
    ctl   = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_zero", 64'(zf), 64'd1);
    chk("rst_carry", 64'(cf), 64'd0);
    chk("rst_ovf", 64'(vf), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ir), 64'd1);
    @(posedge clk);
    #1;

    single(4'd7, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1);
    single(4'd5, 8'd5, 8'd7, 8'd254, 1'b0, 1'b1);
    single(4'd0, 8'd3, 8'd9, 8'd1, 1'b0, 1'b0);
    single(4'd4, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1);

    mul_run(8'd15, 8'd17, 8'd255, 1'b0, 1'b0);
    mul_run(8'd16, 8'd16, 8'd0, 1'b1, 1'b1);

    ordy = 1'b0;
    drive(4'd1, 8'hAA, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(ov), 64'd1);
      chk("bp_res", 64'(res), 64'h0A);
      chk("bp_ready", 64'(ir), 64'd0);
    end
    @(posedge clk);
    #1 ordy = 1'b1;
    drive(4'd6, 8'hF0, 8'hFF);
    @(negedge clk);
    chk("b2b_valid", 64'(ov), 64'd1);
    chk("b2b_res", 64'(res), 64'h0F);
    @(posedge clk);
    #1;

    single(4'd9, 8'h81, 8'd9, 8'h02, 1'b0, 1'b0);
    single(4'd10, 8'h80, 8'd7, 8'h01, 1'b0, 1'b0);
    single(4'd13, 8'h5A, 8'hC3, 8'h00, 1'b1, 1'b0);
    single(4'd2, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0);

    drive(4'd8, 8'd15, 8'd17);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(ov), 64'd0);
    chk("mrst_res", 64'(res), 64'd0);
    chk("mrst_zero", 64'(zf), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ov) seen = 1'b1;
    end
    chk("mrst_stale", 64'(seen), 64'd0);
    chk("mrst_ready", 64'(ir), 64'd1);
    chk("sb8_lost", 64'(q.size()), 64'd0);

    n = 0;
    while (!(sw[0].done && sw[1].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("sweep_done",
        64'({sw[0].done, sw[1].done}), 64'd3);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
